// File: rtl/qar_bus_pkg.sv
// Shared types for the QAR register-bus initiator: op codes, engine states,
// the request record and the masked-compare helper used by POLL.
package qar_bus_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_POLL    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_POLL  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  typedef struct packed {
    op_e                op;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  mask;
  } req_t;

  // True when every bit selected by mask agrees between observed and expected.
  function automatic logic poll_match(input logic [DATA_W-1:0] observed,
                                      input logic [DATA_W-1:0] expected,
                                      input logic [DATA_W-1:0] mask);
    return ((observed ^ expected) & mask) == 32'h0000_0000;
  endfunction

endpackage

// File: rtl/qar_bus_if.sv
// Client request/response channel plus the peripheral strobe bus.
// master = the initiator itself, slave = client and peripheral side.
interface qar_bus_if #(
  parameter int ADDR_W = 6
) ();

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       req_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              bus_write;
  logic              bus_read;
  logic [ADDR_W-1:0] addr_word;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              busy;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, req_mask, rsp_ready, rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_write, bus_read, addr_word, wdata, busy
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, req_mask, rsp_ready, rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_write, bus_read, addr_word, wdata, busy
  );

endinterface

// File: rtl/qar_sync_fifo.sv
// Generic single-clock FIFO with extra-MSB pointers for full/empty detection.
// Head data is read combinationally; pushes while full are dropped.
module qar_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Pointer advance
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {(PTR_W+1){1'b0}};
      rd_ptr_q <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
      end
    end
  end

endmodule

// File: rtl/qar_bus_initiator.sv
// Peripheral-bus master: queues client requests, issues single-cycle strobes,
// runs hardware POLL loops and returns one response per request, in order.
module qar_bus_initiator #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = qar_bus_pkg::ADDR_W,
  parameter int POLL_LIMIT = 1024
) (
  input  logic      clk,
  input  logic      rst,
  qar_bus_if.master bus
);

  import qar_bus_pkg::*;

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);

  // Request record sized to this instance's address width.
  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       mask;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  cmd_t              push_entry;
  cmd_t              head_entry;
  logic [CMD_W-1:0]  head_bits;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              poll_hit;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              bus_write_q, bus_write_d;
  logic              bus_read_q, bus_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  assign push_entry = '{op: op_e'(bus.req_op), addr: bus.req_addr,
                        wdata: bus.req_wdata, mask: bus.req_mask};
  assign head_entry = head_bits;
  assign poll_hit   = poll_match(bus.rdata, cmd_q.wdata, cmd_q.mask);

  qar_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.req_valid),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state logic; strobes are prepared one state ahead so they are registered.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus_write_d = 1'b0;
    bus_read_d  = 1'b0;
    addr_d      = {ADDR_W{1'b0}};
    wdata_d     = 32'h0000_0000;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = head_entry;
          state_d  = ST_ISSUE;
          case (head_entry.op)
            OP_WRITE: begin
              bus_write_d = 1'b1;
              addr_d      = head_entry.addr;
              wdata_d     = head_entry.wdata;
            end
            OP_READ, OP_POLL: begin
              bus_read_d = 1'b1;
              addr_d     = head_entry.addr;
            end
            default: begin
              bus_read_d = 1'b0;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
        case (cmd_q.op)
          OP_WRITE: begin
            rsp_rdata_d = 32'h0000_0000;
          end
          OP_READ: begin
            rsp_rdata_d = bus.rdata;
          end
          OP_POLL: begin
            rsp_rdata_d = bus.rdata;
            cnt_d       = {{(CNT_W-1){1'b0}}, 1'b1};
            if (poll_hit) begin
              rsp_err_d = 1'b0;
            end else if (POLL_LIMIT == 1) begin
              rsp_err_d = 1'b1;
            end else begin
              state_d     = ST_POLL;
              rsp_valid_d = 1'b0;
              bus_read_d  = 1'b1;
              addr_d      = cmd_q.addr;
            end
          end
          default: begin
            rsp_err_d = 1'b1;
          end
        endcase
      end

      // cnt_d is the number of reads issued including this cycle's.
      ST_POLL: begin
        rsp_rdata_d = bus.rdata;
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (poll_hit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
        end else if (cnt_d == CNT_W'(POLL_LIMIT)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          state_d    = ST_POLL;
          bus_read_d = 1'b1;
          addr_d     = cmd_q.addr;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Engine registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '{op: OP_WRITE, addr: {ADDR_W{1'b0}},
                       wdata: 32'h0000_0000, mask: 32'h0000_0000};
      cnt_q       <= {CNT_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      bus_write_q <= 1'b0;
      bus_read_q  <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_write_q <= bus_write_d;
      bus_read_q  <= bus_read_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Strobes are masked by rst so nothing reaches a slave in the reset cycle.
  assign bus.bus_write = bus_write_q & ~rst;
  assign bus.bus_read  = bus_read_q & ~rst;
  assign bus.addr_word = rst ? {ADDR_W{1'b0}} : addr_q;
  assign bus.wdata     = rst ? 32'h0000_0000 : wdata_q;
  assign bus.req_ready = ~fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_qar_bus_initiator.sv
// Scoreboard bench for qar_bus_initiator with a behavioural register slave
// that can also emulate a status bit (mode 1) or a never-ready status (mode 2).
module tb_qar_bus_initiator;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mask;
  } stim_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qar_bus_if #(.ADDR_W(6)) bus_if ();

  qar_bus_initiator #(
    .FIFO_DEPTH (4),
    .ADDR_W     (6),
    .POLL_LIMIT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  stim_t stim_q[$];
  exp_t  exp_q[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int mode     = 0;
  int accept_cnt = 0, accept_cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, rd_run = 0, rsp_cnt = 0, first_valid_cyc = 0;
  logic [5:0]  last_waddr = 6'h00;
  logic [31:0] last_wdata = 32'h0;

  // Slave model state
  logic [31:0] mem [64];
  logic [63:0] wr_seen = 64'h0;
  int          poll_rd = 0;
  int          last_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] wd,
                       input logic [31:0] mk, input logic [31:0] er, input logic ee);
    stim_t s;
    exp_t  e;
    s.op = op; s.addr = addr; s.wdata = wd; s.mask = mk;
    e.rdata = er; e.err = ee;
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  task automatic wait_rsp(input string name, input int n);
    int t = 0;
    while (rsp_cnt < n && t < 300) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check(name, 32'(rsp_cnt), 32'(n));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Slave read data: plain register file, or the poll-target emulations.
  always_comb begin
    bus_if.rdata = 32'h0;
    if (bus_if.bus_read) begin
      if (mode == 1 && bus_if.addr_word == 6'h03)
        bus_if.rdata = 32'h0000_0A00 | {31'h0, (poll_rd >= 4)};
      else if (mode == 2 && bus_if.addr_word == 6'h04)
        bus_if.rdata = 32'h0000_0B00 + 32'(poll_rd);
      else if (wr_seen[bus_if.addr_word])
        bus_if.rdata = mem[bus_if.addr_word];
      else
        bus_if.rdata = 32'h1000_0000 | {26'h0, bus_if.addr_word};
    end
  end

  // Slave state updates
  initial begin
    forever begin
      @(posedge clk);
      last_mode <= mode;
      if (rst) wr_seen <= 64'h0;
      else if (bus_if.bus_write) begin
        mem[bus_if.addr_word]     <= bus_if.wdata;
        wr_seen[bus_if.addr_word] <= 1'b1;
      end
      if (mode != last_mode) poll_rd <= 0;
      else if (bus_if.bus_read) poll_rd <= poll_rd + 1;
    end
  end

  // Request driver
  initial begin
    logic  hs;
    stim_t s;
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 2'b00;
    bus_if.req_addr  = 6'h00;
    bus_if.req_wdata = 32'h0;
    bus_if.req_mask  = 32'h0;
    forever begin
      @(negedge clk);
      hs = bus_if.req_valid && bus_if.req_ready && !rst;
      if (hs) begin
        accept_cnt++;
        accept_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (hs) bus_if.req_valid = 1'b0;
      if (!bus_if.req_valid && stim_q.size() > 0) begin
        s = stim_q.pop_front();
        bus_if.req_op    = s.op;
        bus_if.req_addr  = s.addr;
        bus_if.req_wdata = s.wdata;
        bus_if.req_mask  = s.mask;
        bus_if.req_valid = 1'b1;
      end
    end
  end

  // Bus and response monitor
  initial begin
    exp_t e;
    logic prev_rd = 1'b0, prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_if.bus_read || bus_if.bus_write) begin
          check("strobe_exclusive", {31'h0, bus_if.bus_read & bus_if.bus_write}, 32'h0);
        end else begin
          check("idle_addr", {26'h0, bus_if.addr_word}, 32'h0);
          check("idle_wdata", bus_if.wdata, 32'h0);
        end
        if (bus_if.bus_write) begin
          wr_cnt++;
          last_waddr = bus_if.addr_word;
          last_wdata = bus_if.wdata;
        end
        if (bus_if.bus_read) begin
          rd_cnt++;
          rd_run = prev_rd ? rd_run + 1 : 1;
        end
        prev_rd = bus_if.bus_read;
        if (bus_if.rsp_valid && !prev_valid) first_valid_cyc = cyc;
        prev_valid = bus_if.rsp_valid;
        if (bus_if.rsp_valid && bus_if.rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL rsp_unexpected: got rdata 0x%08h err %0b, want no response",
                     bus_if.rsp_rdata, bus_if.rsp_err);
          end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", bus_if.rsp_rdata, e.rdata);
            check("rsp_err", {31'h0, bus_if.rsp_err}, {31'h0, e.err});
            rsp_cnt++;
          end
        end
      end else begin
        prev_rd    = 1'b0;
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    int w0, r0, a0, n;
    logic [31:0] ev;
    bus_if.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
    check("reset_rsp_rdata", bus_if.rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'h0, bus_if.rsp_err}, 32'h0);
    check("reset_busy", {31'h0, bus_if.busy}, 32'h0);
    check("reset_req_ready", {31'h0, bus_if.req_ready}, 32'h1);
    n = 0;

    // WRITE prescale
    w0 = wr_cnt; r0 = rd_cnt;
    issue(2'b00, 6'h01, 32'h0000_0064, 32'h0, 32'h0, 1'b0);
    n++; wait_rsp("write_done", n);
    check("write_strobes", 32'(wr_cnt - w0), 32'd1);
    check("write_addr", {26'h0, last_waddr}, 32'h1);
    check("write_data", last_wdata, 32'h64);
    check("write_no_read", 32'(rd_cnt - r0), 32'd0);
    check("prescale_reg", mem[1], 32'h64);

    // READ back with latency check
    r0 = rd_cnt;
    issue(2'b01, 6'h01, 32'h0, 32'h0, 32'h0000_0064, 1'b0);
    n++; wait_rsp("read_done", n);
    check("read_strobes", 32'(rd_cnt - r0), 32'd1);
    check("read_latency", 32'(first_valid_cyc - accept_cyc), 32'd3);

    // POLL that matches on the 5th read
    @(posedge clk); #1 mode = 1;
    r0 = rd_cnt;
    issue(2'b10, 6'h03, 32'h1, 32'h1, 32'h0000_0A01, 1'b0);
    n++; wait_rsp("poll_hit_done", n);
    check("poll_hit_reads", 32'(rd_cnt - r0), 32'd5);
    check("poll_hit_run", 32'(rd_run), 32'd5);

    // POLL that never matches: limit of 8 reads
    @(posedge clk); #1 mode = 2;
    r0 = rd_cnt;
    issue(2'b10, 6'h04, 32'hF, 32'hF, 32'h0000_0B07, 1'b1);
    n++; wait_rsp("poll_timeout_done", n);
    check("poll_timeout_reads", 32'(rd_cnt - r0), 32'd8);
    check("poll_timeout_run", 32'(rd_run), 32'd8);

    // Back-pressure: 6 READs with rsp_ready low
    @(posedge clk); #1 mode = 0; bus_if.rsp_ready = 1'b0;
    r0 = rd_cnt; a0 = accept_cnt;
    for (int a = 1; a <= 6; a++) begin
      ev = (a == 1) ? 32'h0000_0064 : (32'h1000_0000 | 32'(a));
      issue(2'b01, 6'(a), 32'h0, 32'h0, ev, 1'b0);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bp_accepted", 32'(accept_cnt - a0), 32'd5);
    check("bp_req_ready", {31'h0, bus_if.req_ready}, 32'h0);
    check("bp_rsp_valid", {31'h0, bus_if.rsp_valid}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_rdata_stable", bus_if.rsp_rdata, 32'h0000_0064);
    end
    @(posedge clk); #1 bus_if.rsp_ready = 1'b1;
    n += 6; wait_rsp("bp_drain", n);
    check("bp_reads", 32'(rd_cnt - r0), 32'd6);

    // Illegal op
    w0 = wr_cnt; r0 = rd_cnt;
    issue(2'b11, 6'h05, 32'h1234_5678, 32'h0, 32'h0, 1'b1);
    n++; wait_rsp("illegal_done", n);
    check("illegal_no_write", 32'(wr_cnt - w0), 32'd0);
    check("illegal_no_read", 32'(rd_cnt - r0), 32'd0);

    // Reset during a POLL
    @(posedge clk); #1 mode = 2;
    r0 = rd_cnt;
    issue(2'b10, 6'h04, 32'hF, 32'hF, 32'h0, 1'b1);
    for (int t = 0; t < 50 && (rd_cnt - r0) < 3; t++) @(negedge clk);
    check("mid_poll_reads_seen", {31'h0, (rd_cnt - r0) >= 3}, 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_bus_read", {31'h0, bus_if.bus_read}, 32'h0);
    check("rst_bus_write", {31'h0, bus_if.bus_write}, 32'h0);
    check("rst_addr_word", {26'h0, bus_if.addr_word}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_rsp_valid", {31'h0, bus_if.rsp_valid}, 32'h0);
    check("post_rst_busy", {31'h0, bus_if.busy}, 32'h0);
    check("post_rst_req_ready", {31'h0, bus_if.req_ready}, 32'h1);
    r0 = rd_cnt;
    repeat (5) @(negedge clk);
    check("post_rst_quiet", 32'(rd_cnt - r0), 32'd0);

    // Normal operation resumes
    @(posedge clk); #1 mode = 0;
    issue(2'b01, 6'h02, 32'h0, 32'h0, 32'h1000_0002, 1'b0);
    n++; wait_rsp("post_rst_read", n);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/qar_bus_initiator.md
Name: qar_bus_initiator

Overview:
Register-bus initiator: the master side of the peripheral bus that the QAR timer and other slaves answer on. A core-side client queues requests through a valid/ready interface. The block converts each request into single-cycle bus_write/bus_read strobes with addr_word/wdata, samples the same-cycle combinational rdata, and returns a response. It also supports a hardware POLL operation, which repeats reads until a masked compare matches or a limit is reached, so that firmware does not spin on status bits.

Parameters:
FIFO_DEPTH, 4, request queue entries (power of two, >=2)
ADDR_W, 6, word-address width of addr_word
POLL_LIMIT, 1024, maximum bus reads per POLL request, including the first (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request offered
req_ready  out  1  request accepted when valid&ready
req_op  in  2  00 WRITE, 01 READ, 10 POLL, 11 illegal
req_addr  in  ADDR_W  target word address
req_wdata  in  32  write data (WRITE) / expected value (POLL)
req_mask  in  32  compare mask (POLL only)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  32  read data / last polled data / 0 for WRITE
rsp_err  out  1  POLL timeout or illegal op
bus_write  out  1  write strobe to slave
bus_read  out  1  read strobe to slave
addr_word  out  ADDR_W  bus address
wdata  out  32  bus write data
rdata  in  32  slave read data, valid in the same cycle as bus_read
busy  out  1  FIFO non-empty or engine not IDLE

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high; state, FIFO pointers, the poll counter and response registers clear on the clk edge where rst=1.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1.
- Strobes during reset: bus_write, bus_read, addr_word and wdata are 0 in every cycle where rst=1, and also whenever no strobe is active.
- Request FIFO:
  - req_ready = !full.
  - Push on valid&ready.
  - A pop and a push in the same cycle are legal when the FIFO is not full.
  - An entry pushed into an empty FIFO is poppable one cycle later at the earliest.
  - No push occurs while full, even if a pop happens in the same cycle.
- FSM: IDLE, ISSUE, POLL, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the command register and go to ISSUE.
  - ISSUE, WRITE: bus_write=1 for exactly one cycle with addr_word=cmd.addr and wdata=cmd.wdata. Response is rdata=0, err=0. Go to RESP.
  - ISSUE, READ: bus_read=1 for one cycle; rdata is registered into rsp_rdata at the end of that cycle. err=0. Go to RESP.
  - ISSUE, POLL: same as READ, and poll_cnt is set to 1.
    - If (rdata & mask) == (wdata & mask), go to RESP with err=0.
    - Else if POLL_LIMIT==1, go to RESP with err=1.
    - Else go to POLL.
  - ISSUE, illegal op: no strobe. Response is rdata=0, err=1. Go to RESP.
  - POLL: bus_read=1 every cycle and poll_cnt increments; rsp_rdata takes the latest rdata.
    - On a match, go to RESP with err=0.
    - When poll_cnt reaches POLL_LIMIT without a match, go to RESP with err=1.
    - Total reads never exceed POLL_LIMIT. Counter width is clog2(POLL_LIMIT+1).
  - RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready. On the handshake, go to IDLE.
- Mutual exclusion: bus_write and bus_read are never high together.
- Ordering: requests execute and respond strictly in order, at most one outstanding.
- Latency (empty FIFO, rsp_ready=1):
  - Request accepted at cycle t.
  - IDLE pops at t+1.
  - Strobe at t+2.
  - rsp_valid at t+3.
  - Throughput is one non-POLL request per 3 cycles.
- Reset mid-operation: an in-progress POLL or a pending response is discarded, and queued requests are flushed. No strobe is issued in the reset cycle.

Decomposition:
- Package qar_bus_pkg:
  - op encodings OP_WRITE/OP_READ/OP_POLL
  - FSM state enum
  - request struct {op, addr, wdata, mask}
  - default ADDR_W=6
- Sub-module qar_sync_fifo: generic synchronous FIFO, params WIDTH/DEPTH, with full/empty. It is reused for the request queue. Everything else lives in qar_bus_initiator.

Test Plan:
- WRITE addr 0x01 wdata 0x00000064 with qar_timer attached -> exactly one cycle with bus_write=1, addr_word=0x01, wdata=0x64. Then rsp_rdata=0, rsp_err=0, and the timer prescale reads back 0x64.
- READ addr 0x01 after the above -> one bus_read cycle, rsp_rdata=0x00000064, rsp_err=0, rsp_valid 3 cycles after acceptance.
- POLL addr 0x03, mask 0x1, value 0x1, against a model slave whose bit0 sets on the 5th read -> exactly 5 consecutive bus_read cycles, rsp_err=0, rsp_rdata bit0=1.
- POLL with POLL_LIMIT=8 and the slave never matching -> exactly 8 bus_read cycles, rsp_err=1, rsp_rdata = last rdata.
- rsp_ready held 0 while 6 READs are offered:
  - 5 are accepted (1 in the engine, 4 queued), then req_ready=0.
  - Response data stays stable.
  - Releasing rsp_ready drains all 6 in order, with 0x01..0x06 addresses reflected.
- Illegal op 11 -> no strobe, rsp_err=1. Separately, rst asserted for 1 cycle mid-POLL -> strobes drop in that cycle, rsp_valid=0, busy=0, req_ready=1 next cycle.
